// File: rtl/alu_filter_sequencer.sv
// Drives the shared 16-bit ALU through add/shift steps to produce one smoothed pixel per request.
// Mode 0: (a + 2b + c) >> 2; mode 1: (a + b) >> 1.
//
// state | meaning
// IDLE  | ALU parked on IDLE_OP, waiting for start
// ADD1  | acc <= pa + pb
// ADD2  | acc <= acc + pb (mode 0 only)
// ADD3  | acc <= acc + pc (mode 0 only)
// SHR2  | result <= acc >> 2
// SHR1  | result <= acc >> 1
// DONE  | done pulse, ALU parked
module alu_filter_sequencer #(
  parameter int          DATA_W  = 16,
  parameter logic [3:0]  IDLE_OP = 4'b0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] pix_a,
  input  logic [DATA_W-1:0] pix_b,
  input  logic [DATA_W-1:0] pix_c,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_c,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SHR2 = 4'b0110;
  localparam logic [3:0] OP_SHR1 = 4'b0111;

  typedef enum logic [2:0] {
    S_IDLE, S_ADD1, S_ADD2, S_ADD3, S_SHR2, S_SHR1, S_DONE
  } state_t;

  state_t            state;
  logic              mode_q;
  logic [DATA_W-1:0] pa, pb, pc, acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mode_q <= 1'b0;
      pa     <= '0;
      pb     <= '0;
      pc     <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pa     <= pix_a;
            pb     <= pix_b;
            pc     <= pix_c;
            mode_q <= mode;
            state  <= S_ADD1;
          end
        end
        S_ADD1: begin
          acc   <= alu_c;
          state <= mode_q ? S_SHR1 : S_ADD2;
        end
        S_ADD2: begin
          acc   <= alu_c;
          state <= S_ADD3;
        end
        S_ADD3: begin
          acc   <= alu_c;
          state <= S_SHR2;
        end
        S_SHR2, S_SHR1: begin
          result <= alu_c;
          state  <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ALU buses decode from flops only, so pixel inputs never reach the ALU combinationally.
  always_comb begin
    alu_ctrl = IDLE_OP;
    alu_a    = '0;
    alu_b    = '0;
    case (state)
      S_ADD1: begin alu_ctrl = OP_ADD;  alu_a = pa;  alu_b = pb; end
      S_ADD2: begin alu_ctrl = OP_ADD;  alu_a = acc; alu_b = pb; end
      S_ADD3: begin alu_ctrl = OP_ADD;  alu_a = acc; alu_b = pc; end
      S_SHR2: begin alu_ctrl = OP_SHR2; alu_a = acc; end
      S_SHR1: begin alu_ctrl = OP_SHR1; alu_a = acc; end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_alu_filter_sequencer.sv
// Directed bench for alu_filter_sequencer with a behavioural ALU and an expected-result queue.
module tb_alu_filter_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] pix_a = '0, pix_b = '0, pix_c = '0;
  logic [3:0]  alu_ctrl;
  logic [15:0] alu_a, alu_b, alu_c;
  logic        busy, done;
  logic [15:0] result;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_a, exp_b;

  alu_filter_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .pix_a(pix_a), .pix_b(pix_b), .pix_c(pix_c),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_c = 16'h0000;
    case (alu_ctrl)
      4'b0100: alu_c = alu_a + alu_b;
      4'b0110: alu_c = alu_a >> 2;
      4'b0111: alu_c = alu_a >> 1;
      default: alu_c = 16'h0000;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic m, input logic [15:0] a, b, c);
    logic [17:0] s;
    if (m) begin
      s = {2'b00, a} + {2'b00, b};
      return 16'(s[15:0] >> 1);
    end
    s = {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    return 16'(s[15:0] >> 2);
  endfunction

  // Drive a request at a falling edge; returns just after the accepting edge.
  task automatic req(input logic m, input logic [15:0] a, b, c, input bit hold);
    mode = m; pix_a = a; pix_b = b; pix_c = c; start = 1'b1;
    exp_a = a; exp_b = b;
    exp_q.push_back(model(m, a, b, c));
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Walks the op from the accepting edge through DONE and the following IDLE cycle.
  task automatic wait_done(input logic m);
    int lat;
    logic [3:0] seq[5];
    lat = m ? 2 : 4;
    if (m) seq = '{4'b0100, 4'b0111, 4'b0001, 4'b0001, 4'b0001};
    else   seq = '{4'b0100, 4'b0100, 4'b0100, 4'b0110, 4'b0001};
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      chk($sformatf("ctrl_k%0d", k), {12'h0, alu_ctrl}, {12'h0, seq[k]});
      chk($sformatf("busy_k%0d", k), {15'h0, busy}, 16'h1);
      if (k == 0) begin
        chk("alu_a_add1", alu_a, exp_a);
        chk("alu_b_add1", alu_b, exp_b);
      end
      if (k < lat) begin
        chk($sformatf("done_low_k%0d", k), {15'h0, done}, 16'h0);
      end else begin
        chk("done_high", {15'h0, done}, 16'h1);
        if (exp_q.size() == 0) chk("queue_empty", 16'h1, 16'h0);
        else chk("result", result, exp_q.pop_front());
      end
    end
    @(negedge clk);
    chk("done_pulse_end", {15'h0, done}, 16'h0);
    chk("idle_after_done", {15'h0, busy}, 16'h0);
  endtask

  initial begin
    logic [15:0] ra, rb, rc;
    logic        rm;
    logic [15:0] held;

    // Asynchronous reset assertion mid-cycle
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", {15'h0, busy}, 16'h0);
    chk("rst_done", {15'h0, done}, 16'h0);
    chk("rst_result", result, 16'h0);
    chk("rst_ctrl", {12'h0, alu_ctrl}, 16'h0001);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", {15'h0, busy}, 16'h0);
      chk("idle_ctrl", {12'h0, alu_ctrl}, 16'h0001);
      chk("idle_result", result, 16'h0);
    end

    req(1'b0, 16'd10, 16'd20, 16'd30, 1'b0);
    wait_done(1'b0);
    chk("basic_m0_value", result, 16'd20);

    req(1'b1, 16'd7, 16'd12, 16'hABCD, 1'b0);
    wait_done(1'b1);
    chk("basic_m1_value", result, 16'd9);

    req(1'b0, 16'hFFFF, 16'h8000, 16'hFFFF, 1'b0);
    wait_done(1'b0);
    chk("wrap_value", result, 16'h3FFF);

    // Start held high with changed pixels through the whole op: ignored until IDLE
    req(1'b0, 16'd100, 16'd40, 16'd8, 1'b1);
    mode = 1'b1; pix_a = 16'd500; pix_b = 16'd300; pix_c = 16'd1;
    wait_done(1'b0);
    chk("busy_ignore_value", result, 16'd47);
    exp_a = 16'd500; exp_b = 16'd300;
    exp_q.push_back(model(1'b1, 16'd500, 16'd300, 16'd1));
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1'b1);
    chk("held_start_value", result, 16'd400);

    // Reset during ADD3
    req(1'b0, 16'd1000, 16'd2000, 16'd3000, 1'b0);
    held = exp_q.pop_back();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_ctrl_add3", {12'h0, alu_ctrl}, 16'h0004);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {15'h0, busy}, 16'h0);
    chk("midrst_done", {15'h0, done}, 16'h0);
    chk("midrst_result", result, 16'h0);
    chk("midrst_ctrl", {12'h0, alu_ctrl}, 16'h0001);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", {15'h0, done}, 16'h0);
      chk("post_rst_result", result, 16'h0);
    end
    chk("dropped_request_nonzero", 16'(held != 16'h0), 16'h1);

    req(1'b1, 16'd31, 16'd33, 16'd0, 1'b0);
    wait_done(1'b1);
    chk("post_rst_value", result, 16'd32);

    for (int i = 0; i < 6; i++) begin
      rm = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 16'($urandom);
      req(rm, ra, rb, rc, 1'b0);
      wait_done(rm);
    end

    chk("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
